mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_mem_stream_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads a burst of consecutive words from the read port of a dual-port RAM
// (fixed one-cycle read latency) and streams them out over a valid/ready
// interface through a 2-entry output FIFO. Reads are throttled so that the
// FIFO plus the read in flight never hold more than two words, which lets
// the stream run at one word per cycle without ever dropping returned data.
module mem_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   REMAIN_ONE = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_remain;     // words still to be issued
  logic [ADDR_WIDTH-1:0] r_next_addr;  // address of the next issue
  logic [ADDR_WIDTH-1:0] r_last_addr;  // address of the most recent issue
  logic                  r_inflight;   // a read was issued last cycle
  logic [1:0]            r_count;      // FIFO occupancy, 0..2
  logic [DATA_WIDTH-1:0] r_head;       // FIFO head, drives out_data
  logic [DATA_WIDTH-1:0] r_tail;       // second FIFO entry
  logic                  r_done;

  logic                  w_start_ok;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_finish;

  // A start is only honoured in IDLE and not in the cycle done is pulsing.
  assign w_start_ok = (r_state == IDLE) && start && !r_done;

  // The word in flight lands in the FIFO the cycle after its issue.
  assign w_push = r_inflight;
  assign w_pop  = (r_count != 2'd0) && out_ready;

  // Words already committed to the output path once this cycle's pop leaves.
  // A pop implies r_count >= 1, so this never underflows.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == RUN) && (r_remain != '0) && (w_occ < 3'd2);

  // Burst is complete when nothing is left to issue, nothing is returning,
  // and the FIFO drains to empty at this edge.
  assign w_finish = (r_state == RUN) && (r_remain == '0) && !r_inflight &&
                    ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  assign mem_re    = w_issue;
  assign mem_we    = 1'b0;
  assign mem_addr  = w_issue ? r_next_addr : r_last_addr;
  assign out_data  = r_head;
  assign out_valid = (r_count != 2'd0);
  assign busy      = (r_state == RUN);
  assign done      = r_done;

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on an accepted start, RUN -> IDLE when drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = RUN;
      RUN:  if (w_finish)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Done is a registered one-cycle pulse in the first IDLE cycle after RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
    end
  end

  // Burst bookkeeping: load base/length on start, advance on every issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain    <= '0;
      r_next_addr <= '0;
      r_last_addr <= '0;
    end else if (w_start_ok) begin
      r_remain    <= length;
      r_next_addr <= base_addr;
    end else if (w_issue) begin
      r_remain    <= r_remain - REMAIN_ONE;
      r_next_addr <= r_next_addr + ADDR_ONE;
      r_last_addr <= r_next_addr;
    end
  end

  // In-flight flag; clearing it on reset discards the returning read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Two-entry output FIFO with the head held in its own register so
  // out_data comes straight from a flop. The issue throttle guarantees no
  // push arrives while two words are already waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= mem_q;
          end else begin
            r_tail <= mem_q;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= mem_q;
          end else begin
            r_head <= r_tail;
            r_tail <= mem_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader: a RAM model with one-cycle read latency,
// a queue of expected words built from base/length, and per-cycle protocol
// invariants on issue addresses, FIFO room, hold behaviour and done/busy timing.
module tb_mem_stream_reader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_q     (mem_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:DEPTH-1];

  always @(posedge clk) mem_q <= ram[mem_addr];

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            cyc;
  int            cur_base, cur_len;
  int            n_issued, n_popped, n_busy;
  int            done_cyc, first_issue, first_valid;
  logic [AW-1:0] last_addr;
  bit            held;
  logic [DW-1:0] held_data;
  bit            mon_en;
  logic          s_busy, s_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, then step past the rising edge.
  task automatic tick();
    logic          pop;
    logic [AW-1:0] ea;
    @(negedge clk);
    if (mon_en) begin
      pop = out_valid && out_ready;
      if (mem_re) begin
        ea = AW'(cur_base + n_issued);
        check("issue_addr", 64'(mem_addr), 64'(ea));
        check("issue_room", 64'((n_issued - n_popped - int'(pop)) < 2), 64'(1));
        check("issue_count", 64'(n_issued < cur_len), 64'(1));
        if (first_issue < 0) first_issue = cyc;
        n_issued++;
        last_addr = mem_addr;
      end else begin
        check("addr_hold", 64'(mem_addr), 64'(last_addr));
      end
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(held_data));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (pop) begin
        if (exp_q.size() == 0) check("extra_word", 64'(out_data), 64'hDEAD_0000_0000);
        else check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        n_popped++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (busy) n_busy++;
      if (done && done_cyc < 0) done_cyc = cyc;
      check("mem_we", 64'(mem_we), 64'(0));
    end
    s_busy = busy;
    s_done = done;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_re"}, 64'(mem_re), 64'(0));
    check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return !(c >= 4 && c <= 9);
      2: return ($urandom_range(0, 3) != 0);
      default: return ($urandom_range(0, 1) != 0);
    endcase
  endfunction

  task automatic begin_burst(input int base, input int len);
    cur_base = base;
    cur_len = len;
    n_issued = 0;
    n_popped = 0;
    n_busy = 0;
    done_cyc = -1;
    first_issue = -1;
    first_valid = -1;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ram[AW'(base + i)]);
    base_addr = AW'(base);
    length = (AW + 1)'(len);
    start = 1'b1;
    cyc = 0;
  endtask

  // Run one burst to completion; ghost adds ignored starts while busy and on done.
  task automatic run_burst(input int base, input int len, input int mode, input bit ghost);
    int budget;
    begin_burst(base, len);
    out_ready = ready_for(mode, 0);
    tick();
    start = 1'b0;
    budget = 4 * len + 100;
    while (done_cyc < 0 && cyc < budget) begin
      out_ready = ready_for(mode, cyc);
      start = ghost && (cyc == 2 || cyc == len + 3);
      base_addr = AW'($urandom);
      length = (AW + 1)'($urandom_range(1, 30));
      tick();
    end
    start = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'(1));
    check("words_left", 64'(exp_q.size()), 64'(0));
    check("words_issued", 64'(n_issued), 64'(len));
    check("busy_span", 64'(n_busy), 64'(done_cyc - 1));
    if (mode == 0) check("done_cycle", 64'(done_cyc), 64'((len == 0) ? 2 : len + 3));
    if (len > 0) begin
      check("first_issue", 64'(first_issue), 64'(1));
      check("first_valid", 64'(first_valid), 64'(3));
    end else begin
      check("no_valid", 64'(first_valid), 64'(-1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("idle_busy", 64'(s_busy), 64'(0));
      check("idle_done", 64'(s_done), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b1;
    mon_en = 1'b0;
    held = 1'b0;
    last_addr = '0;
    cyc = 0;
    cur_base = 0;
    cur_len = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");
    mon_en = 1'b1;

    // Identity RAM, base 5, four words.
    run_burst(5, 4, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

    // Wrap at top of memory.
    run_burst(4094, 4, 0, 1'b0);
    // Consumer stall in cycles 4-9.
    run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0);
    // Zero-length burst.
    run_burst(int'($urandom_range(0, DEPTH - 1)), 0, 0, 1'b0);

    // Reset in cycle 3 of a 10-word burst, then a fresh 2-word burst from 0.
    begin_burst(20, 10);
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    held = 1'b0;
    last_addr = '0;
    check_zero("midrst");
    run_burst(0, 2, 0, 1'b0);

    // Starts pulsed while busy and while done is high are ignored.
    run_burst(int'($urandom_range(0, DEPTH - 1)), 6, 0, 1'b1);

    for (int t = 0; t < 10; t++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 3)), 1'b0);

    // Full-memory burst at full rate.
    run_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
